cache_stats: RTL

- Statistics block downstream of the instruction and data caches.
- Consumes their per-access hit/miss flags and the trace command code `n`.
- Keeps saturating hit and miss counters per cache and exposes them through a registered read port.
- Computes a fixed-point hit ratio on request, using a sequential restoring divider, for the end-of-run report.

---
 rtl/cache_stats.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cache_stats.sv
// cache_stats: hit/miss statistics for the instruction and data caches.
// Four saturating counters sit behind a registered read port. A restoring
// divider computes the fixed-point hit ratio hits * 2^FRAC_W / (hits + misses)
// from a snapshot of one cache's counters.
module cache_stats #(
  parameter int CNT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        n,
  input  logic              i_hit,
  input  logic              i_miss,
  input  logic              d_hit,
  input  logic              d_miss,
  input  logic [1:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  input  logic              ratio_req,
  input  logic              ratio_sel,
  output logic              ratio_busy,
  output logic              ratio_done,
  output logic [FRAC_W:0]   ratio_q
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [3:0] CMD_RESET = 4'd8;

  localparam int QW = FRAC_W + 1;          // quotient width, 1.0 representable
  localparam int TW = CNT_W + 1;           // hits + misses never overflows
  localparam int RW = CNT_W + 2;           // remainder holds 2*rem + 1
  localparam int BW = $clog2(FRAC_W + 2);  // bit counter holds FRAC_W+1

  // Counter order matches rd_sel: I hits, I misses, D hits, D misses
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] r_rd_data;

  logic [1:0]       r_state;
  logic [TW-1:0]    r_tot;
  logic [RW-1:0]    r_rem;
  logic [QW-1:0]    r_dvd;
  logic [QW-1:0]    r_quot;
  logic [BW-1:0]    r_bits;
  logic [QW-1:0]    r_ratio_q;
  logic             r_done;

  logic [3:0]       w_flag;
  logic             w_clr;
  logic [CNT_W-1:0] w_hits;
  logic [CNT_W-1:0] w_miss;
  logic [TW-1:0]    w_total;
  logic [RW-1:0]    w_shift;
  logic [RW-1:0]    w_sub;
  logic             w_fit;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_flag  = {d_miss, d_hit, i_miss, i_hit};
  assign w_clr   = (n == CMD_RESET);

  assign w_hits  = ratio_sel ? r_cnt[2] : r_cnt[0];
  assign w_miss  = ratio_sel ? r_cnt[3] : r_cnt[1];
  assign w_total = {1'b0, w_hits} + {1'b0, w_miss};

  // One restoring step: bring in the next dividend bit and trial-subtract T.
  // The remainder stays below T, so its top bit is always clear; folding it
  // into the fit test keeps the step correct even if it were not.
  assign w_shift = {r_rem[RW-2:0], r_dvd[QW-1]};
  assign w_sub   = w_shift - {1'b0, r_tot};
  assign w_fit   = (w_shift >= {1'b0, r_tot}) | r_rem[RW-1];

  // Saturating counters; the clear command beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_clr)          r_cnt[i] <= '0;
        else if (w_flag[i]) r_cnt[i] <= sat_inc(r_cnt[i]);
      end
    end
  end

  // Read port returns the counter value from before this edge's update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_cnt[rd_sel];
  end

  // Ratio FSM: snapshot operands, divide one quotient bit per cycle, publish.
  // The dividend is hits << FRAC_W. Every dividend bit above position FRAC_W
  // yields a zero quotient bit (hits >> 1 < T), so the remainder starts at
  // hits >> 1 and only the last FRAC_W+1 dividend bits are iterated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tot     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_quot    <= '0;
      r_bits    <= '0;
      r_ratio_q <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ratio_req) begin
            r_tot  <= w_total;
            r_quot <= '0;
            if (w_total == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_DIV;
              r_bits  <= BW'(QW);
              r_rem   <= RW'(w_hits >> 1);
              r_dvd   <= {w_hits[0], {FRAC_W{1'b0}}};
            end
          end
        end
        S_DIV: begin
          r_rem  <= w_fit ? w_sub : w_shift;
          r_quot <= {r_quot[QW-2:0], w_fit};
          r_dvd  <= {r_dvd[QW-2:0], 1'b0};
          r_bits <= r_bits - BW'(1);
          if (r_bits == BW'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_ratio_q <= r_quot;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign ratio_busy = (r_state != S_IDLE);
  assign ratio_done = r_done;
  assign ratio_q    = r_ratio_q;

endmodule
